// File: rtl/mips_bus_pkg.sv
// Shared types for the CPU-bus memory responder: Avalon response codes,
// responder FSM states and the captured request record.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } avalon_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } mem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
  } bus_req_t;

endpackage

// File: rtl/mips_bus_mem_responder_if.sv
// Avalon-MM style CPU bus between the MIPS master and a memory slave.
interface mips_bus_mem_responder_if;
  import mips_bus_pkg::*;

  logic [31:0]  address;
  logic [3:0]   byteenable;
  logic         read;
  logic         write;
  logic [31:0]  writedata;
  logic         waitrequest;
  logic [31:0]  readdata;
  avalon_resp_t response;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, response
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, response
  );
endinterface

// File: rtl/mips_bus_mem_array.sv
// Word-wide RAM with per-byte-lane synchronous write and asynchronous read.
module mips_bus_mem_array #(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = "",
  parameter int    AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  // NOTE: storage has no reset; only control state is cleared, so contents survive a bus reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mips_bus_mem_responder.sv
// Avalon-MM memory slave for the MIPS CPU bus: captures one request, inserts
// WAIT_CYCLES wait states, then acknowledges with registered data and response.
module mips_bus_mem_responder
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input logic                     clk,
  input logic                     reset,
  mips_bus_mem_responder_if.slave bus
);

  localparam int          AW       = $clog2(MEM_WORDS);
  localparam logic [32:0] END_OFF  = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_t   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  bus_req_t     req_q, req_d;
  logic [31:0]  rdata_q, rdata_d;
  avalon_resp_t resp_q, resp_d;

  bus_req_t     live_req, eval_req;
  logic [31:0]  offset;
  logic         in_range;
  avalon_resp_t eval_resp;
  logic [31:0]  mem_rdata;
  logic         mem_we;
  logic         req_active;

  assign live_req = '{addr: bus.address, be: bus.byteenable, wdata: bus.writedata,
                      rd: bus.read, wr: bus.write};

  // Decode the live bus in IDLE (needed for zero wait states), the captured copy otherwise.
  assign eval_req = (state_q == ST_IDLE) ? live_req : req_q;
  assign offset   = eval_req.addr - BASE_ADDR;
  assign in_range = (eval_req.addr >= BASE_ADDR) && ({1'b0, offset} < END_OFF);

  always_comb begin
    eval_resp = RESP_OKAY;
    if ((eval_req.rd && eval_req.wr) || (eval_req.addr[1:0] != 2'b00)) eval_resp = RESP_SLVERR;
    else if (!in_range)                                                eval_resp = RESP_DECERR;
  end

  mips_bus_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE),
    .AW        (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (req_q.be),
    .addr_i  (offset[AW+1:2]),
    .wdata_i (req_q.wdata),
    .rdata_o (mem_rdata)
  );

  assign req_active      = bus.read | bus.write;
  assign bus.waitrequest = req_active && (state_q != ST_ACK);
  assign bus.readdata    = rdata_q;
  assign bus.response    = resp_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_active) begin
          req_d = live_req;
          cnt_d = '0;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
            resp_d  = eval_resp;
            rdata_d = (eval_resp == RESP_OKAY) ? mem_rdata : '0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req_active) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_ACK;
          resp_d  = eval_resp;
          rdata_d = (eval_resp == RESP_OKAY) ? mem_rdata : '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        mem_we  = req_q.wr && (eval_resp == RESP_OKAY);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) driven with directed
// and random transfers; expectations come from a word-level memory model.
module tb_mips_bus_mem_responder;

  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam int          WORDS = 1024;

  typedef struct {
    logic [1:0]  resp;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_bus_mem_responder_if bus2();
  mips_bus_mem_responder_if bus0();

  mips_bus_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_CYCLES(2), .INIT_FILE(""))
    u_dut_w2 (.clk(clk), .reset(rst_n), .bus(bus2));
  mips_bus_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_CYCLES(0), .INIT_FILE(""))
    u_dut_w0 (.clk(clk), .reset(rst_n), .bus(bus0));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_cnt2 = 0;
  int ack_cnt0 = 0;
  int ack_cyc0[$];
  exp_t exp2[$];
  exp_t exp0[$];
  logic [31:0] mem2 [int];
  logic [31:0] mem0 [int];
  exp_t mon_e2, mon_e0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: every accepted cycle pops one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus2.read || bus2.write) && bus2.waitrequest === 1'b0) begin
      ack_cnt2++;
      check("w2_ack_expected", 32'(exp2.size() != 0), 32'd1);
      if (exp2.size() != 0) begin
        mon_e2 = exp2.pop_front();
        check("w2_response", 32'(bus2.response), 32'(mon_e2.resp));
        if (mon_e2.chk_data) check("w2_readdata", bus2.readdata, mon_e2.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus0.read || bus0.write) && bus0.waitrequest === 1'b0) begin
      ack_cnt0++;
      ack_cyc0.push_back(cyc);
      check("w0_ack_expected", 32'(exp0.size() != 0), 32'd1);
      if (exp0.size() != 0) begin
        mon_e0 = exp0.pop_front();
        check("w0_response", 32'(bus0.response), 32'(mon_e0.resp));
        if (mon_e0.chk_data) check("w0_readdata", bus0.readdata, mon_e0.data);
      end
    end
  end

  function automatic logic [1:0] ref_resp(input logic [31:0] a, input bit rd, input bit wr);
    longint unsigned la = longint'(a);
    longint unsigned lo = longint'(BASE);
    longint unsigned hi = longint'(BASE) + 4 * WORDS;
    if ((rd && wr) || (a % 4 != 0)) return 2'b10;
    if (la < lo || la >= hi) return 2'b11;
    return 2'b00;
  endfunction

  task automatic set_inputs(input int which, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
    if (which == 2) begin
      bus2.read = rd; bus2.write = wr; bus2.address = a; bus2.byteenable = be; bus2.writedata = wd;
    end else begin
      bus0.read = rd; bus0.write = wr; bus0.address = a; bus0.byteenable = be; bus0.writedata = wd;
    end
  endtask

  // Model: compute the expected response and apply a successful write.
  task automatic push_expect(input int which, input bit rd, input bit wr, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    int idx;
    bit known;
    logic [31:0] w;
    e.resp = ref_resp(a, rd, wr);
    e.chk_data = 1'b0;
    e.data = '0;
    idx = int'((a - BASE) / 4);
    known = (which == 2) ? mem2.exists(idx) : mem0.exists(idx);
    if (rd && !wr) begin
      if (e.resp != 2'b00) e.chk_data = 1'b1;
      else if (known) begin
        e.chk_data = 1'b1;
        e.data = (which == 2) ? mem2[idx] : mem0[idx];
      end
    end
    if (wr && !rd && e.resp == 2'b00 && (known || be == 4'hF)) begin
      w = known ? ((which == 2) ? mem2[idx] : mem0[idx]) : 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      if (which == 2) mem2[idx] = w; else mem0[idx] = w;
    end
    if (which == 2) exp2.push_back(e); else exp0.push_back(e);
  endtask

  // Called just after a rising edge with the request already driven.
  task automatic wait_ack(input int which, output int waits, output bit acked);
    logic wr_now;
    waits = 0;
    acked = 1'b0;
    for (int k = 0; k < 20 && !acked; k++) begin
      @(negedge clk);
      wr_now = (which == 2) ? bus2.waitrequest : bus0.waitrequest;
      if (wr_now) waits++; else acked = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input int which, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    int waits;
    bit acked;
    push_expect(which, rd, wr, a, be, wd);
    set_inputs(which, rd, wr, a, be, wd);
    wait_ack(which, waits, acked);
    set_inputs(which, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check((which == 2) ? "w2_ack_in_budget" : "w0_ack_in_budget", 32'(acked), 32'd1);
    if (acked) check((which == 2) ? "w2_wait_cycles" : "w0_wait_cycles", waits, (which == 2) ? 3 : 1);
  endtask

  task automatic random_ops(input int which, input int n);
    logic [31:0] a;
    bit rd, wr;
    int k, r;
    for (int j = 0; j < n; j++) begin
      k = $urandom_range(0, 9);
      if (k == 0) a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (k == 1) begin
        r = $urandom_range(0, 3);
        a = (r == 0) ? BASE - 4 : (r == 1) ? BASE + 4 * WORDS : (r == 2) ? BASE + 4 * WORDS + 4 * $urandom_range(1, 50) : 32'h0;
      end else a = BASE + 4 * $urandom_range(0, 15);
      r = $urandom_range(0, 9);
      rd = (r == 0) || (r >= 5);
      wr = (r <= 4);
      issue(which, rd, wr, a, 4'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    int waits_a, waits_b;
    bit acked_a, acked_b;
    int acks_before;
    logic [31:0] exp_hold;

    rst_n = 1'b0;
    set_inputs(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_inputs(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_w2_readdata", bus2.readdata, 32'h0);
    check("reset_w2_response", 32'(bus2.response), 32'h0);
    check("reset_w2_waitrequest", 32'(bus2.waitrequest), 32'h0);
    check("reset_w0_response", 32'(bus0.response), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(2, 1'b0, 1'b1, BASE + 4 * i, 4'hF, $urandom);
      issue(0, 1'b0, 1'b1, BASE + 4 * i, 4'hF, $urandom);
    end

    // Full-word write and readback.
    issue(2, 1'b0, 1'b1, 32'hBFC0_0010, 4'hF, 32'hDEAD_BEEF);
    issue(2, 1'b1, 1'b0, 32'hBFC0_0010, 4'h0, 32'h0);
    // Single-lane merge.
    issue(2, 1'b0, 1'b1, 32'hBFC0_0004, 4'hF, 32'h1122_3344);
    issue(2, 1'b0, 1'b1, 32'hBFC0_0004, 4'b0001, 32'h0000_00AA);
    issue(2, 1'b1, 1'b0, 32'hBFC0_0004, 4'hF, 32'h0);
    // Decode boundaries and misalignment.
    issue(2, 1'b1, 1'b0, 32'hBFC0_1000, 4'hF, 32'h0);
    issue(2, 1'b1, 1'b0, 32'hBFC0_0002, 4'hF, 32'h0);
    issue(2, 1'b0, 1'b1, 32'hBFC0_0FFC, 4'hF, 32'hCAFE_F00D);
    issue(2, 1'b1, 1'b0, 32'hBFC0_0FFC, 4'hF, 32'h0);
    issue(2, 1'b1, 1'b0, 32'hBFBF_FFFC, 4'hF, 32'h0);
    // Empty byteenable writes nothing.
    issue(2, 1'b0, 1'b1, 32'hBFC0_0010, 4'h0, 32'h1234_5678);
    issue(2, 1'b1, 1'b0, 32'hBFC0_0010, 4'hF, 32'h0);
    // Simultaneous read and write is an error and writes nothing.
    issue(2, 1'b0, 1'b1, 32'hBFC0_0008, 4'hF, 32'h5566_7788);
    issue(2, 1'b1, 1'b1, 32'hBFC0_0008, 4'hF, 32'h0BAD_0BAD);
    issue(2, 1'b1, 1'b0, 32'hBFC0_0008, 4'hF, 32'h0);

    // Reset in the middle of a wait state.
    set_inputs(2, 1'b1, 1'b0, 32'hBFC0_0010, 4'hF, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    set_inputs(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("midreset_waitrequest", 32'(bus2.waitrequest), 32'h0);
    check("midreset_readdata", bus2.readdata, 32'h0);
    check("midreset_response", 32'(bus2.response), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(2, 1'b1, 1'b0, 32'hBFC0_0010, 4'hF, 32'h0);

    // Abort during WAIT: no acknowledge, outputs hold the previous read.
    exp_hold = mem2[4];
    acks_before = ack_cnt2;
    set_inputs(2, 1'b1, 1'b0, 32'hBFC0_0004, 4'hF, 32'h0);
    @(posedge clk); #1;
    set_inputs(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_ack", ack_cnt2, acks_before);
    check("abort_readdata_held", bus2.readdata, exp_hold);
    check("abort_response_held", 32'(bus2.response), 32'h0);
    issue(2, 1'b1, 1'b0, 32'hBFC0_0004, 4'hF, 32'h0);

    // Zero wait states: held read re-accepted fresh, acknowledges two cycles apart.
    push_expect(0, 1'b1, 1'b0, BASE, 4'hF, 32'h0);
    push_expect(0, 1'b1, 1'b0, BASE + 4, 4'hF, 32'h0);
    set_inputs(0, 1'b1, 1'b0, BASE, 4'hF, 32'h0);
    wait_ack(0, waits_a, acked_a);
    set_inputs(0, 1'b1, 1'b0, BASE + 4, 4'hF, 32'h0);
    wait_ack(0, waits_b, acked_b);
    set_inputs(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("b2b_first_ack", 32'(acked_a), 32'd1);
    check("b2b_second_ack", 32'(acked_b), 32'd1);
    check("b2b_first_waits", waits_a, 1);
    check("b2b_second_waits", waits_b, 1);
    if (ack_cyc0.size() >= 2)
      check("b2b_ack_spacing", ack_cyc0[ack_cyc0.size() - 1] - ack_cyc0[ack_cyc0.size() - 2], 2);
    else
      check("b2b_ack_count", ack_cyc0.size(), 2);

    random_ops(2, 40);
    random_ops(0, 25);

    repeat (3) @(posedge clk);
    check("w2_queue_drained", exp2.size(), 0);
    check("w0_queue_drained", exp0.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
